// File: rtl/rip_nr1w_bram_byte_clr_if.sv
// Bus bundle for the N-read / 1-write byte-enabled block RAM.
// master = client driving requests, slave = the memory.
interface rip_nr1w_bram_byte_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_RD     = 2
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                           init_busy;
    logic                           wr_en;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [BE_WIDTH-1:0]            wr_be;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic [NUM_RD-1:0]              rd_en;
    logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0]   rd_data;
    logic [NUM_RD-1:0]              rd_valid;

    modport master (
        input  init_busy, rd_data, rd_valid,
        output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr
    );

    modport slave (
        output init_busy, rd_data, rd_valid,
        input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr
    );
endinterface

// File: rtl/rip_nr1w_bram_byte_clr.sv
// Block RAM with one byte-enabled write port and NUM_RD read ports.
// Each read port owns a replicated copy of the array; all copies see every write.
// Optional post-reset zero-fill sweep, write-first forwarding and output register.
//
// state   | meaning
// S_CLEAR | zero-fill sweep, one word per cycle; bus requests ignored
// S_READY | normal operation until next rst
module rip_nr1w_bram_byte_clr #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int NUM_RD         = 2,
    parameter int OUT_REG        = 0,
    parameter int WRITE_FIRST    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic                       clk,
    input logic                       rst,
    rip_nr1w_bram_byte_clr_if.slave   bus
);
    localparam int B_WIDTH = 8;
    localparam int NB      = DATA_WIDTH / B_WIDTH;
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {S_CLEAR, S_READY} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
    logic                  clr_we;
    logic                  busy;
    logic                  wr_acc;

    // Sweep FSM state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Sweep FSM next state; counter parks on the last word
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            S_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = S_READY;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
                end
            end
            S_READY: state_nxt = S_READY;
            default: state_nxt = RST_STATE;
        endcase
    end

    assign busy          = (state == S_CLEAR);
    assign bus.init_busy = busy;
    assign wr_acc        = bus.wr_en & ~busy;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [ADDR_WIDTH-1:0] addr;
        logic                  acc;
        logic [DATA_WIDTH-1:0] raw;
        logic                  hit;
        logic [NB-1:0]         fwd_be;
        logic [DATA_WIDTH-1:0] fwd_data;
        logic                  v1;
        logic [DATA_WIDTH-1:0] merged;

        assign addr = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign acc  = bus.rd_en[p] & ~busy;

        // Array copy for this port: sweep writes zeros, otherwise byte-enabled write
        always_ff @(posedge clk) begin
            if (clr_we) begin
                mem[clr_cnt] <= '0;
            end else if (wr_acc) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.wr_be[b]) begin
                        mem[bus.wr_addr][b*B_WIDTH +: B_WIDTH] <= bus.wr_data[b*B_WIDTH +: B_WIDTH];
                    end
                end
            end
        end

        // First read stage: stored word plus captured write for forwarding
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                raw      <= '0;
                hit      <= 1'b0;
                fwd_be   <= '0;
                fwd_data <= '0;
                v1       <= 1'b0;
            end else begin
                v1 <= acc;
                if (acc) begin
                    raw      <= mem[addr];
                    hit      <= (WRITE_FIRST != 0) && wr_acc && (addr == bus.wr_addr);
                    fwd_be   <= bus.wr_be;
                    fwd_data <= bus.wr_data;
                end
            end
        end

        // Forwarding mux: overlay bytes written in the same cycle as the read
        always_comb begin
            merged = raw;
            for (int b = 0; b < NB; b++) begin
                if (hit && fwd_be[b]) begin
                    merged[b*B_WIDTH +: B_WIDTH] = fwd_data[b*B_WIDTH +: B_WIDTH];
                end
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] data2;
            logic                  v2;

            // Second output stage; holds data when no read completes
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data2 <= '0;
                    v2    <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        data2 <= merged;
                    end
                end
            end

            assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data2;
            assign bus.rd_valid[p]                          = v2;
        end else begin : g_noreg
            assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = merged;
            assign bus.rd_valid[p]                          = v1;
        end
    end
endmodule

// File: tb/tb_rip_nr1w_bram_byte_clr.sv
// Directed bench for rip_nr1w_bram_byte_clr, ADDR_WIDTH=4, two read ports.
module tb_rip_nr1w_bram_byte_clr;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int NRD = 2;
    localparam int OUT_REG     = 0;
    localparam int WRITE_FIRST = 1;
    localparam int LAT = 1 + OUT_REG;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    rip_nr1w_bram_byte_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD)) bus ();

    rip_nr1w_bram_byte_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD),
        .OUT_REG(OUT_REG), .WRITE_FIRST(WRITE_FIRST), .CLEAR_ON_RESET(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // Stimulus: one write, entered and left on a falling edge
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.wr_be = '0;
    endtask

    // Stimulus: single read on both ports, returns data, valid, and valid one cycle later
    task automatic rd_one(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          output logic [31:0] d0, output logic [31:0] d1,
                          output logic [1:0] v, output logic [1:0] v_after);
        bus.rd_en = 2'b11; bus.rd_addr = {a1, a0};
        @(negedge clk);
        bus.rd_en = 2'b00;
        repeat (LAT - 1) @(negedge clk);
        d0 = bus.rd_data[31:0]; d1 = bus.rd_data[63:32]; v = bus.rd_valid;
        @(negedge clk);
        v_after = bus.rd_valid;
    endtask

    task automatic test_reset();
        int cnt;
        logic seen_v;
        logic [31:0] d0, d1;
        logic [1:0] v, va;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.init_busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", bus.init_busy); end
        total++; if (bus.rd_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", bus.rd_valid); end
        total++; if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.rd_data); end
        rst = 1'b0;
        bus.rd_en = 2'b11; bus.rd_addr = 8'h21;
        cnt = 0; seen_v = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rd_valid !== 2'b00) seen_v = 1'b1;
            if (bus.init_busy !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        bus.rd_en = 2'b00;
        total++; if (cnt !== 16) begin bad++; $display("FAIL sweep_len got=%0d exp=16", cnt); end
        total++; if (seen_v !== 1'b0) begin bad++; $display("FAIL sweep_rd_ignored got=%b exp=0", seen_v); end
        for (int a = 0; a < 16; a++) begin
            rd_one(AW'(a), AW'(15 - a), d0, d1, v, va);
            total++; if ({d1, d0} !== 64'h0) begin bad++; $display("FAIL clear_data a=%0d got=%h exp=0", a, {d1, d0}); end
            total++; if (v !== 2'b11) begin bad++; $display("FAIL clear_valid a=%0d got=%b exp=11", a, v); end
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] d0, d1;
        logic [1:0] v, va;
        do_write(4'd5, 32'hDEADBEEF, 4'b1111);
        do_write(4'd5, 32'h11223344, 4'b0101);
        do_write(4'd5, 32'hFFFFFFFF, 4'b0000);
        rd_one(4'd5, 4'd5, d0, d1, v, va);
        total++; if (d0 !== 32'hDE22BE44) begin bad++; $display("FAIL bw_p0 got=%h exp=DE22BE44", d0); end
        total++; if (d1 !== 32'hDE22BE44) begin bad++; $display("FAIL bw_p1 got=%h exp=DE22BE44", d1); end
        total++; if (v !== 2'b11) begin bad++; $display("FAIL bw_valid got=%b exp=11", v); end
        total++; if (va !== 2'b00) begin bad++; $display("FAIL bw_pulse got=%b exp=00", va); end
    endtask

    task automatic test_rdw();
        logic [31:0] exp, d0, d1;
        logic [1:0] v, va;
        exp = (WRITE_FIRST != 0) ? 32'hDE22CCDD : 32'hDE22BE44;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 32'hAABBCCDD; bus.wr_be = 4'b0011;
        bus.rd_en = 2'b11; bus.rd_addr = {4'd5, 4'd5};
        @(negedge clk);
        bus.wr_en = 1'b0; bus.wr_be = '0; bus.rd_en = 2'b00;
        repeat (LAT - 1) @(negedge clk);
        total++; if (bus.rd_data[31:0] !== exp) begin bad++; $display("FAIL rdw_p0 got=%h exp=%h", bus.rd_data[31:0], exp); end
        total++; if (bus.rd_data[63:32] !== exp) begin bad++; $display("FAIL rdw_p1 got=%h exp=%h", bus.rd_data[63:32], exp); end
        @(negedge clk);
        rd_one(4'd5, 4'd4, d0, d1, v, va);
        total++; if (d0 !== 32'hDE22CCDD) begin bad++; $display("FAIL raw_after got=%h exp=DE22CCDD", d0); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) do_write(AW'(i), f(i), 4'b1111);
        for (int c = 0; c < 8 + LAT; c++) begin
            if (c >= LAT) begin
                total++; if (bus.rd_data[31:0] !== f(c - LAT)) begin bad++; $display("FAIL b2b_p0 k=%0d got=%h exp=%h", c - LAT, bus.rd_data[31:0], f(c - LAT)); end
                total++; if (bus.rd_data[63:32] !== f(7 - (c - LAT))) begin bad++; $display("FAIL b2b_p1 k=%0d got=%h exp=%h", c - LAT, bus.rd_data[63:32], f(7 - (c - LAT))); end
                total++; if (bus.rd_valid !== 2'b11) begin bad++; $display("FAIL b2b_valid k=%0d got=%b exp=11", c - LAT, bus.rd_valid); end
            end
            if (c < 8) begin
                bus.rd_en = 2'b11; bus.rd_addr = {AW'(7 - c), AW'(c)};
            end else begin
                bus.rd_en = 2'b00;
            end
            @(negedge clk);
        end
        total++; if (bus.rd_valid !== 2'b00) begin bad++; $display("FAIL b2b_end got=%b exp=00", bus.rd_valid); end
    endtask

    task automatic test_hold();
        logic [31:0] d0, d1;
        logic [1:0] v, va;
        rd_one(4'd2, 4'd6, d0, d1, v, va);
        total++; if ({d1, d0} !== {f(6), f(2)}) begin bad++; $display("FAIL hold_first got=%h exp=%h", {d1, d0}, {f(6), f(2)}); end
        do_write(4'd2, 32'h12345678, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.rd_data !== {f(6), f(2)}) begin bad++; $display("FAIL hold_data i=%0d got=%h exp=%h", i, bus.rd_data, {f(6), f(2)}); end
            total++; if (bus.rd_valid !== 2'b00) begin bad++; $display("FAIL hold_valid i=%0d got=%b exp=00", i, bus.rd_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        logic seen_v;
        logic [31:0] d0, d1;
        logic [1:0] v, va;
        bus.rd_en = 2'b11; bus.rd_addr = {4'd3, 4'd3};
        @(posedge clk);
        #1 rst = 1'b1;
        bus.rd_en = 2'b00;
        #1;
        total++; if (bus.rd_valid !== 2'b00) begin bad++; $display("FAIL inflight_valid got=%b exp=00", bus.rd_valid); end
        total++; if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL inflight_data got=%h exp=0", bus.rd_data); end
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        total++; if (bus.init_busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", bus.init_busy); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.init_busy !== 1'b1) begin bad++; $display("FAIL rerst_busy got=%b exp=1", bus.init_busy); end
        rst = 1'b0;
        bus.rd_en = 2'b11; bus.rd_addr = {4'd2, 4'd2};
        cnt = 0; seen_v = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rd_valid !== 2'b00) seen_v = 1'b1;
            if (bus.init_busy !== 1'b1) break;
            cnt++;
            if (i == 10) begin
                bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 32'hFFFFFFFF; bus.wr_be = 4'b1111;
            end else begin
                bus.wr_en = 1'b0; bus.wr_be = '0;
            end
            @(negedge clk);
        end
        bus.rd_en = 2'b00; bus.wr_en = 1'b0;
        total++; if (cnt !== 16) begin bad++; $display("FAIL resweep_len got=%0d exp=16", cnt); end
        total++; if (seen_v !== 1'b0) begin bad++; $display("FAIL resweep_valid got=%b exp=0", seen_v); end
        rd_one(4'd2, 4'd3, d0, d1, v, va);
        total++; if (d0 !== 32'h0) begin bad++; $display("FAIL sweep_wr_dropped got=%h exp=0", d0); end
        total++; if (d1 !== 32'h0) begin bad++; $display("FAIL recleared_3 got=%h exp=0", d1); end
        rd_one(4'd5, 4'd7, d0, d1, v, va);
        total++; if ({d1, d0} !== 64'h0) begin bad++; $display("FAIL recleared_5_7 got=%h exp=0", {d1, d0}); end
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_be = '0; bus.wr_data = '0;
        bus.rd_en = '0; bus.rd_addr = '0;
        @(negedge clk);
        test_reset();
        test_byte_write();
        test_rdw();
        test_back_to_back();
        test_hold();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
